// File: rtl/delay_scheduler.sv
// delay_scheduler
//   Shared millisecond-delay engine. One prescaled counter is handed
//   round-robin to N_REQ requesters; the owner gets a one-cycle done
//   pulse when its requested delay has elapsed.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; pick next requester at/after rr pointer
//   RUN   | prescaler + ms count running for the granted requester
//   DONE  | done pulse to owner, grant still held for this cycle
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   i_req     in   [N_REQ]        level request per requester
//   i_dly_ms  in   [N_REQ*DLY_W]  delay per requester, sampled at grant
//   o_grant   out  [N_REQ]        one-hot owner, zero when idle
//   o_done    out  [N_REQ]        one-cycle completion pulse to owner
//   o_busy    out                 high in RUN and DONE
module delay_scheduler #(
  parameter int N_REQ      = 4,
  parameter int DLY_W      = 8,
  parameter int CYC_PER_MS = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*DLY_W-1:0] i_dly_ms,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int PS_W  = $clog2(CYC_PER_MS);
  localparam logic [PS_W-1:0] PS_TERM = PS_W'(CYC_PER_MS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;
  logic [N_REQ-1:0] r_mask;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [PS_W-1:0]  r_presc;
  logic [DLY_W-1:0] r_ms;
  logic [DLY_W-1:0] r_dly;

  logic [N_REQ-1:0] w_eff;
  logic             w_found;
  logic [PTR_W-1:0] w_sel;
  logic [N_REQ-1:0] w_sel_oh;
  logic [DLY_W-1:0] w_sel_dly;
  logic [PTR_W-1:0] w_next_ptr;
  logic             w_owner_req;
  logic [DLY_W-1:0] w_dly_m1;

  // Rotating priority search: offset 0 is the rr pointer itself.
  always_comb begin
    int j;
    j       = 0;
    w_eff   = i_req & ~r_mask;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && w_eff[j]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    w_sel_oh  = '0;
    w_sel_dly = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_sel == PTR_W'(k)) begin
        w_sel_oh[k] = 1'b1;
        w_sel_dly   = i_dly_ms[k*DLY_W +: DLY_W];
      end
    end
  end

  assign w_next_ptr  = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
  // r_grant is one-hot on the owner, so this is req[owner].
  assign w_owner_req = |(i_req & r_grant);
  assign w_dly_m1    = r_dly - DLY_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_mask  <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_presc <= '0;
      r_ms    <= '0;
      r_dly   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Mask only has to cover the single cycle after DONE.
          r_mask <= '0;
          if (w_found) begin
            r_grant <= w_sel_oh;
            r_owner <= w_sel;
            r_dly   <= w_sel_dly;
            r_presc <= '0;
            r_ms    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_mask  <= '0;
            r_state <= S_IDLE;
          end else if (r_dly == '0) begin
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else if (r_presc == PS_TERM) begin
            r_presc <= '0;
            r_ms    <= r_ms + DLY_W'(1);
            if (r_ms == w_dly_m1) begin
              r_done  <= r_grant;
              r_state <= S_DONE;
            end
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_mask  <= r_grant;
          r_ptr   <= w_next_ptr;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_done  = r_done;
  assign o_busy  = r_busy;

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shared millisecond-delay engine that time-multiplexes a single prescaled counter among `N_REQ` requesters (I2C sequencer, door actuator logic, debouncers). Each requester asks for a delay of `dly_ms` milliseconds. The block grants the counter round-robin, runs the delay, and returns a one-cycle `done` pulse to the owner. It replaces per-requester free-running ms counters in the top level.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `DLY_W`, default 8: width of each delay request, in ms.
- `CYC_PER_MS`, default 50000: clk cycles per ms tick (must be ≥ 2).
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, `N_REQ`: level request per requester; held high until `done` or abort.
- `dly_ms`, in, `N_REQ*DLY_W`: delay for requester k is bits `[k*DLY_W +: DLY_W]`; sampled at grant.
- `grant`, out, `N_REQ`: one-hot owner of the counter; all zero when idle.
- `done`, out, `N_REQ`: one-cycle completion pulse to the owner.
- `busy`, out, 1: high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, `grant=0`, `done=0`, `busy=0`, prescaler=0, ms count=0, rr pointer=0, mask=0.
- **IDLE:** `eff = req & ~mask`.
  - If `eff` is nonzero, select the first set bit at or after the rr pointer, wrapping modulo `N_REQ`.
  - Register `grant[k]=1`, latch `dly_ms[k]`, clear the prescaler and ms count, then go to RUN.
  - `mask` is cleared on every IDLE cycle.
- **RUN:**
  - The prescaler counts 0..`CYC_PER_MS`-1 and wraps.
  - At prescaler terminal, the ms count increments.
  - When the prescaler is at terminal and the ms count equals latched `dly-1`, go to DONE.
- **Zero delay:** a latched `dly=0` goes RUN→DONE on the first RUN cycle.
- **DONE:**
  - `done[k]=1` for exactly this cycle and `grant[k]` stays high.
  - Next cycle: `grant=0`, `mask=one-hot(k)`, rr pointer=(k+1) mod `N_REQ`, state IDLE.
  - The mask prevents re-grant to k on the cycle before it observes `done` and drops `req`.
- **Abort:** `req[k]` low while in RUN means: next cycle IDLE, `grant=0`, no `done`, rr pointer=(k+1) mod `N_REQ`, mask=0.
- Requests from non-owners are ignored until IDLE; there is no queueing beyond the `req` levels themselves.
- `dly_ms` changes after grant have no effect on the running delay.
- **Reset mid-RUN:** immediate return to reset values; no `done` is emitted.
- **Arithmetic:**
  - Prescaler width is `$clog2(CYC_PER_MS)`; ms count width is `DLY_W`.
  - The compare uses the latched delay minus 1, which is valid for `dly≥1`.
  - Maximum delay is 255 ms at default width; the counter never overflows.

## Timing
- Grant latency: `req` high in IDLE at edge t gives `grant` high from edge t+1.
- Delay: with latched `dly=D≥1`, RUN lasts exactly `D*CYC_PER_MS` cycles. `done` is high in the cycle after the last RUN cycle, so the grant→done edge distance is `D*CYC_PER_MS`. For D=0 it is 1 cycle.
- Back-to-back service: after DONE, the next requester's grant appears at the earliest 2 cycles after the `done` edge (IDLE, then grant).
- Worst-case wait for requester k: `(N_REQ-1)` full delays of the others, plus 2 cycles each.
- All outputs are registered; no combinational path from `req` to `grant` or `done`.

## Test plan
- **Single request:** set `CYC_PER_MS=4`. `req[0]=1` with `dly=3` → `grant=0001` one cycle later; `done[0]` pulses exactly 12 cycles after the grant edge; `grant` clears the following cycle; `busy` is high throughout.
- **Round-robin:** `req=1111` simultaneously, all with `dly=1` → grant order 0,1,2,3, each `done` 4 cycles after its grant, grants spaced 6 cycles. Then re-raise `req[0]` and `req[3]` after the last done with pointer=0 → 0 is served first.
- **Mask/hold:** `req[2]` is held high one cycle after its `done` → no re-grant to 2 on that cycle. If 2 keeps `req` high it is re-granted only after the pointer wraps and no other requester is pending.
- **Zero delay:** `dly[1]=0` → `done[1]` exactly 1 cycle after `grant[1]`.
- **Abort:** drop `req[1]` 5 cycles into a `dly=4` run → `grant` clears next cycle, no `done`; pending `req[2]` is granted 1 cycle after that.
- **Reset mid-run:** assert `reset` for 1 cycle during RUN → `grant=0`, `done=0`, `busy=0` on the next edge; a subsequent `req[3]` is granted with a full, fresh delay.
